hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the five-stage MIPS core: the successor to the combinational hazard unit. It generates EX/ID forwarding selects, HI/LO forwarding, and load-use and branch stalls as before. It adds an internal multi-cycle divide sequencer, data-memory wait stalls, and exception flushing with a fixed priority. It sits beside the datapath and drives every pipeline-register stall and flush enable.

---
 rtl/hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use/branch stalls,
// multi-cycle divide sequencer, memory-wait stalls and exception flushing.
module hazard_ctrl #(
  parameter int unsigned AW         = 5,
  parameter int unsigned DIV_CYCLES = 34,
  parameter int unsigned CW         = 6
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [AW-1:0] i_rsD,
  input  logic [AW-1:0] i_rtD,
  input  logic          i_branchD,
  input  logic          i_jumpregD,
  input  logic [AW-1:0] i_rsE,
  input  logic [AW-1:0] i_rtE,
  input  logic [AW-1:0] i_writeregE,
  input  logic          i_regwriteE,
  input  logic          i_memtoregE,
  input  logic          i_divE,
  input  logic [1:0]    i_hilowriteE,
  input  logic [1:0]    i_hilowriteM,
  input  logic [1:0]    i_hilowriteW,
  input  logic [AW-1:0] i_writeregM,
  input  logic [AW-1:0] i_writeregW,
  input  logic          i_regwriteM,
  input  logic          i_memtoregM,
  input  logic          i_regwriteW,
  input  logic          i_memstallM,
  input  logic          i_exceptM,
  output logic          o_forwardaD,
  output logic          o_forwardbD,
  output logic [1:0]    o_forwardaE,
  output logic [1:0]    o_forwardbE,
  output logic [1:0]    o_forwardhiloE,
  output logic          o_stallF,
  output logic          o_stallD,
  output logic          o_stallE,
  output logic          o_stallM,
  output logic          o_flushD,
  output logic          o_flushE,
  output logic          o_flushM,
  output logic          o_flushW,
  output logic          o_divstartE,
  output logic          o_divdoneE,
  output logic          o_divbusy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_divstart;
  logic          w_dstall;
  logic          w_lwstall;
  logic          w_brstall;
  logic          w_matchE;
  logic          w_matchM;

  // Divide sequencer state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Divide sequencer next state; an exception aborts from any state
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_divstart  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_divE && !i_exceptM) begin
          w_divstart  = 1'b1;
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = CW'(DIV_CYCLES - 1);
        end
      end
      S_BUSY: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (!i_memstallM) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_exceptM) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end
  end

  assign w_dstall    = w_divstart || (r_state == S_BUSY);
  assign o_divstartE = w_divstart;
  assign o_divdoneE  = (r_state == S_DONE);
  assign o_divbusy   = (r_state != S_IDLE);

  // Forwarding selects; register 0 is hardwired and never forwarded
  always_comb begin
    o_forwardaE    = 2'b00;
    o_forwardbE    = 2'b00;
    o_forwardhiloE = 2'b00;
    if (i_rsE != '0 && i_rsE == i_writeregM && i_regwriteM)      o_forwardaE = 2'b10;
    else if (i_rsE != '0 && i_rsE == i_writeregW && i_regwriteW) o_forwardaE = 2'b01;
    if (i_rtE != '0 && i_rtE == i_writeregM && i_regwriteM)      o_forwardbE = 2'b10;
    else if (i_rtE != '0 && i_rtE == i_writeregW && i_regwriteW) o_forwardbE = 2'b01;
    if (i_hilowriteE == 2'b00 && i_hilowriteM != 2'b00)      o_forwardhiloE = 2'b01;
    else if (i_hilowriteE == 2'b00 && i_hilowriteW != 2'b00) o_forwardhiloE = 2'b10;
  end

  assign o_forwardaD = (i_rsD != '0) && (i_rsD == i_writeregM) && i_regwriteM;
  assign o_forwardbD = (i_rtD != '0) && (i_rtD == i_writeregM) && i_regwriteM;

  assign w_lwstall = i_memtoregE && (i_writeregE != '0) &&
                     ((i_writeregE == i_rsD) || (i_writeregE == i_rtD));

  // Branch/jr operands still being produced in EX or loaded in MEM
  assign w_matchE  = i_regwriteE && (i_writeregE != '0) &&
                     ((i_writeregE == i_rsD) || (i_writeregE == i_rtD));
  assign w_matchM  = i_memtoregM && (i_writeregM != '0) &&
                     ((i_writeregM == i_rsD) || (i_writeregM == i_rtD));
  assign w_brstall = (i_branchD || i_jumpregD) && (w_matchE || w_matchM);

  // Stall/flush priority: exception > memory wait > divide > load-use/branch
  always_comb begin
    o_stallF = 1'b0;
    o_stallD = 1'b0;
    o_stallE = 1'b0;
    o_stallM = 1'b0;
    o_flushD = 1'b0;
    o_flushE = 1'b0;
    o_flushM = 1'b0;
    o_flushW = 1'b0;
    if (i_exceptM) begin
      o_flushD = 1'b1;
      o_flushE = 1'b1;
      o_flushM = 1'b1;
      o_flushW = 1'b1;
    end else begin
      o_stallM = i_memstallM;
      o_stallE = i_memstallM || w_dstall;
      o_stallF = o_stallE || w_lwstall || w_brstall;
      o_stallD = o_stallF;
      o_flushE = (w_lwstall || w_brstall) && !o_stallE;
      o_flushM = w_dstall && !i_memstallM;
      o_flushW = i_memstallM;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected output words are queued as each
// step is driven and checked against the DUT on the following falling edge.
module tb_hazard_ctrl;

  localparam int unsigned AW  = 5;
  localparam int unsigned DIV = 34;
  localparam int unsigned CW  = 6;

  // Output word layout: faD fbD faE[2] fbE[2] fhilo[2] sF sD sE sM fD fE fM fW ds dd db
  localparam logic [18:0] FAD   = 19'(1) << 18;
  localparam logic [18:0] FBD   = 19'(1) << 17;
  localparam logic [18:0] FAE_M = 19'(2) << 15;
  localparam logic [18:0] FAE_W = 19'(1) << 15;
  localparam logic [18:0] FBE_M = 19'(2) << 13;
  localparam logic [18:0] FBE_W = 19'(1) << 13;
  localparam logic [18:0] FH_M  = 19'(1) << 11;
  localparam logic [18:0] FH_W  = 19'(2) << 11;
  localparam logic [18:0] SF    = 19'(1) << 10;
  localparam logic [18:0] SD    = 19'(1) << 9;
  localparam logic [18:0] SE    = 19'(1) << 8;
  localparam logic [18:0] SM    = 19'(1) << 7;
  localparam logic [18:0] FD    = 19'(1) << 6;
  localparam logic [18:0] FE    = 19'(1) << 5;
  localparam logic [18:0] FM    = 19'(1) << 4;
  localparam logic [18:0] FW    = 19'(1) << 3;
  localparam logic [18:0] DS    = 19'(1) << 2;
  localparam logic [18:0] DD    = 19'(1) << 1;
  localparam logic [18:0] DB    = 19'(1);
  localparam logic [18:0] ZERO  = 19'(0);
  localparam logic [18:0] LW    = SF | SD | FE;
  localparam logic [18:0] DIVS  = SF | SD | SE | FM;
  localparam logic [18:0] EXC   = FD | FE | FM | FW;

  logic          i_clk, i_rst_n;
  logic [AW-1:0] i_rsD, i_rtD, i_rsE, i_rtE, i_writeregE, i_writeregM, i_writeregW;
  logic          i_branchD, i_jumpregD, i_regwriteE, i_memtoregE, i_divE;
  logic [1:0]    i_hilowriteE, i_hilowriteM, i_hilowriteW;
  logic          i_regwriteM, i_memtoregM, i_regwriteW, i_memstallM, i_exceptM;
  logic          o_forwardaD, o_forwardbD;
  logic [1:0]    o_forwardaE, o_forwardbE, o_forwardhiloE;
  logic          o_stallF, o_stallD, o_stallE, o_stallM;
  logic          o_flushD, o_flushE, o_flushM, o_flushW;
  logic          o_divstartE, o_divdoneE, o_divbusy;
  logic [18:0]   w_obs;

  typedef struct {
    string       tag;
    logic [18:0] v;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  hazard_ctrl #(.AW(AW), .DIV_CYCLES(DIV), .CW(CW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_rsD(i_rsD), .i_rtD(i_rtD), .i_branchD(i_branchD), .i_jumpregD(i_jumpregD),
    .i_rsE(i_rsE), .i_rtE(i_rtE), .i_writeregE(i_writeregE),
    .i_regwriteE(i_regwriteE), .i_memtoregE(i_memtoregE), .i_divE(i_divE),
    .i_hilowriteE(i_hilowriteE), .i_hilowriteM(i_hilowriteM), .i_hilowriteW(i_hilowriteW),
    .i_writeregM(i_writeregM), .i_writeregW(i_writeregW),
    .i_regwriteM(i_regwriteM), .i_memtoregM(i_memtoregM), .i_regwriteW(i_regwriteW),
    .i_memstallM(i_memstallM), .i_exceptM(i_exceptM),
    .o_forwardaD(o_forwardaD), .o_forwardbD(o_forwardbD),
    .o_forwardaE(o_forwardaE), .o_forwardbE(o_forwardbE), .o_forwardhiloE(o_forwardhiloE),
    .o_stallF(o_stallF), .o_stallD(o_stallD), .o_stallE(o_stallE), .o_stallM(o_stallM),
    .o_flushD(o_flushD), .o_flushE(o_flushE), .o_flushM(o_flushM), .o_flushW(o_flushW),
    .o_divstartE(o_divstartE), .o_divdoneE(o_divdoneE), .o_divbusy(o_divbusy)
  );

  assign w_obs = {o_forwardaD, o_forwardbD, o_forwardaE, o_forwardbE, o_forwardhiloE,
                  o_stallF, o_stallD, o_stallE, o_stallM,
                  o_flushD, o_flushE, o_flushM, o_flushW,
                  o_divstartE, o_divdoneE, o_divbusy};

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic clr();
    i_rsD = '0; i_rtD = '0; i_rsE = '0; i_rtE = '0;
    i_writeregE = '0; i_writeregM = '0; i_writeregW = '0;
    i_branchD = 1'b0; i_jumpregD = 1'b0; i_regwriteE = 1'b0; i_memtoregE = 1'b0;
    i_divE = 1'b0; i_hilowriteE = 2'b00; i_hilowriteM = 2'b00; i_hilowriteW = 2'b00;
    i_regwriteM = 1'b0; i_memtoregM = 1'b0; i_regwriteW = 1'b0;
    i_memstallM = 1'b0; i_exceptM = 1'b0;
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [18:0] expv);
    exp_t e;
    e.tag = tag;
    e.v   = expv;
    q.push_back(e);
    @(negedge i_clk);
    e = q.pop_front();
    n_cmp++;
    assert (w_obs === e.v)
      else begin
        n_err++;
        $error("FAIL %s observed=%05h expected=%05h", e.tag, w_obs, e.v);
      end
  endtask

  initial begin
    i_rst_n = 1'b0;
    clr();
    #2;
    chk("reset", ZERO);
    cyc();
    i_rst_n = 1'b1;
    chk("post_reset_idle", ZERO);

    // EX forwarding: MEM vs WB sources, MEM priority, r0 and write-enable gating
    cyc(); i_rsE = 5'd4; i_writeregM = 5'd4; i_regwriteM = 1'b1;
    i_rtE = 5'd7; i_writeregW = 5'd7; i_regwriteW = 1'b1;
    chk("fwdE_mem_wb", FAE_M | FBE_W);
    cyc(); clr(); i_rsE = 5'd6; i_rtE = 5'd6; i_writeregM = 5'd6; i_writeregW = 5'd6;
    i_regwriteM = 1'b1; i_regwriteW = 1'b1;
    chk("fwdE_mem_priority", FAE_M | FBE_M);
    cyc(); clr(); i_regwriteM = 1'b1; i_regwriteW = 1'b1;
    chk("fwdE_r0", ZERO);
    cyc(); clr(); i_rsE = 5'd6; i_writeregM = 5'd6; i_writeregW = 5'd6; i_regwriteW = 1'b1;
    chk("fwdE_wb_only", FAE_W);

    // HI/LO forwarding
    cyc(); clr(); i_hilowriteM = 2'b10; i_hilowriteW = 2'b01;
    chk("hilo_mem", FH_M);
    cyc(); clr(); i_hilowriteW = 2'b11;
    chk("hilo_wb", FH_W);
    cyc(); clr(); i_hilowriteE = 2'b01; i_hilowriteM = 2'b10;
    chk("hilo_ex_writes", ZERO);

    // Load-use
    cyc(); clr(); i_memtoregE = 1'b1; i_writeregE = 5'd5; i_rtD = 5'd5;
    chk("lwstall", LW);
    cyc(); clr(); i_memtoregE = 1'b1;
    chk("lwstall_r0", ZERO);

    // Branch stall then MEM forward to comparator; jr on a MEM load
    cyc(); clr(); i_branchD = 1'b1; i_rsD = 5'd3; i_regwriteE = 1'b1; i_writeregE = 5'd3;
    chk("brstall_ex", LW);
    cyc(); clr(); i_branchD = 1'b1; i_rsD = 5'd3; i_writeregM = 5'd3; i_regwriteM = 1'b1;
    chk("br_fwdD", FAD);
    cyc(); clr(); i_jumpregD = 1'b1; i_rtD = 5'd9; i_writeregM = 5'd9;
    i_memtoregM = 1'b1; i_regwriteM = 1'b1;
    chk("jr_load_mem", FBD | LW);

    // Full divide with a one-cycle divE pulse
    cyc(); clr(); i_divE = 1'b1;
    chk("div_start", DIVS | DS);
    cyc(); i_divE = 1'b0;
    for (int k = 1; k < int'(DIV); k++) begin
      chk("div_busy", DIVS | DB);
      cyc();
    end
    chk("div_done", DD | DB);
    cyc();
    chk("div_idle", ZERO);

    // Divide finishing under a 3-cycle memory wait
    cyc(); i_divE = 1'b1;
    chk("div2_start", DIVS | DS);
    cyc(); i_divE = 1'b0;
    for (int k = 1; k < int'(DIV); k++) cyc();
    i_memstallM = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("div2_done_mstall", DD | DB | SF | SD | SE | SM | FW);
      cyc();
    end
    i_memstallM = 1'b0;
    chk("div2_done_release", DD | DB);
    cyc();
    chk("div2_idle", ZERO);

    // Memory wait during BUSY, then exception with a load-use pending
    cyc(); i_divE = 1'b1;
    chk("div3_start", DIVS | DS);
    cyc(); i_divE = 1'b0; i_memstallM = 1'b1;
    chk("div3_busy_mstall", SF | SD | SE | SM | FW | DB);
    cyc(); i_memstallM = 1'b0; i_exceptM = 1'b1;
    i_memtoregE = 1'b1; i_writeregE = 5'd5; i_rsD = 5'd5;
    chk("div3_except", EXC | DB);
    cyc(); clr();
    chk("div3_aborted", ZERO);

    // Exception on the same cycle as divE
    cyc(); i_divE = 1'b1; i_exceptM = 1'b1;
    chk("div_except_same", EXC);
    cyc(); clr();
    chk("div_except_nostart", ZERO);

    // Reset mid-divide at cnt=20
    cyc(); i_divE = 1'b1;
    chk("div4_start", DIVS | DS);
    cyc(); i_divE = 1'b0;
    for (int k = 1; k < 14; k++) begin
      chk("div4_busy", DIVS | DB);
      cyc();
    end
    i_rst_n = 1'b0;
    chk("div4_reset", ZERO);
    cyc(); i_rst_n = 1'b1;
    for (int k = 0; k < 36; k++) begin
      chk("div4_no_done", ZERO);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
